// File: rtl/fc8_sysctl.sv
// fc8_sysctl: memory-mapped system controller for fc8_cpu.
// Answers a 16-byte I/O window at BASE holding a 16-bit down-counter timer,
// a sticky interrupt status/enable pair driving irq_n, and an NMI pulse
// generator driving nmi_n.
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   addr, wdata, we  - CPU bus (address, write data, write enable)
//   rdata, hit       - registered read data and in-window read flag
//   irq_n, nmi_n     - registered active-low interrupt outputs
//   ext_irq          - synchronous active-high peripheral interrupt lines
//   nmi_btn          - asynchronous raw NMI request
module fc8_sysctl #(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter int unsigned NMI_PULSE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        irq_n,
  output logic        nmi_n,
  input  logic [2:0]  ext_irq,
  input  logic        nmi_btn
);

  localparam logic [7:0] PULSE_LEN = 8'(NMI_PULSE);

  localparam logic [3:0] OFF_TRL    = 4'd0;
  localparam logic [3:0] OFF_TRH    = 4'd1;
  localparam logic [3:0] OFF_TCTRL  = 4'd2;
  localparam logic [3:0] OFF_CNTL   = 4'd3;
  localparam logic [3:0] OFF_CNTH   = 4'd4;
  localparam logic [3:0] OFF_ISTAT  = 4'd5;
  localparam logic [3:0] OFF_IEN    = 4'd6;
  localparam logic [3:0] OFF_NMICTL = 4'd7;

  logic [7:0]  trl_q, trl_d, trh_q, trh_d;
  logic        en_q, en_d, ar_q, ar_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [3:0]  istat_q, istat_d, ien_q, ien_d;
  logic        nmien_q, nmien_d;
  logic [2:0]  ext_prev_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        hit_q, hit_d, irq_n_q, irq_n_d, nmi_n_q, nmi_n_d;

  logic        in_win_s, wr_s, rd_s;
  logic [3:0]  off_s;
  logic [15:0] reload_s;
  logic [7:0]  rd_mux_s;
  logic        timer_evt_s, nmi_rise_s;
  logic [3:0]  istat_clr_s;

  // Address decode: the window is the 16 bytes whose upper 12 bits match BASE
  always_comb begin
    in_win_s = (addr[15:4] == BASE[15:4]);
    off_s    = addr[3:0];
    wr_s     = in_win_s & we;
    rd_s     = in_win_s & ~we;
    reload_s = {trh_q, trl_q};
  end

  // Read mux over the register values as they stand at this edge
  always_comb begin
    case (off_s)
      OFF_TRL:    rd_mux_s = trl_q;
      OFF_TRH:    rd_mux_s = trh_q;
      OFF_TCTRL:  rd_mux_s = {6'b000000, ar_q, en_q};
      OFF_CNTL:   rd_mux_s = count_q[7:0];
      OFF_CNTH:   rd_mux_s = shadow_q;
      OFF_ISTAT:  rd_mux_s = {4'b0000, istat_q};
      OFF_IEN:    rd_mux_s = {4'b0000, ien_q};
      OFF_NMICTL: rd_mux_s = {7'b0000000, nmien_q};
      default:    rd_mux_s = 8'h00;
    endcase
  end

  // Timer, register writes, interrupt status and NMI pulse next-state
  always_comb begin
    trl_d       = trl_q;
    trh_d       = trh_q;
    en_d        = en_q;
    ar_d        = ar_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    ien_d       = ien_q;
    nmien_d     = nmien_q;
    timer_evt_s = 1'b0;
    istat_clr_s = 4'h0;

    // Timer step; a one-shot parks at zero and drops EN
    if (en_q) begin
      if (count_q == 16'h0000) begin
        timer_evt_s = 1'b1;
        if (ar_q) begin
          count_d = reload_s;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q - 16'h0001;
      end
    end else begin
      count_d = count_q;
    end

    // A bus write overrides the timer's own EN update in the same cycle
    if (wr_s) begin
      case (off_s)
        OFF_TRL:    trl_d = wdata;
        OFF_TRH:    trh_d = wdata;
        OFF_TCTRL: begin
          count_d = (wdata[0] && !en_q) ? reload_s : count_d;
          en_d    = wdata[0];
          ar_d    = wdata[1];
        end
        OFF_ISTAT:  istat_clr_s = wdata[3:0];
        OFF_IEN:    ien_d = wdata[3:0];
        OFF_NMICTL: nmien_d = wdata[0];
        default:    trl_d = trl_q;
      endcase
    end else begin
      istat_clr_s = 4'h0;
    end

    // CNTL reads snapshot the high byte so a later CNTH read is coherent
    if (rd_s && (off_s == OFF_CNTL)) begin
      shadow_d = count_q[15:8];
    end else begin
      shadow_d = shadow_q;
    end

    // Sets are OR-ed in after the clear so a same-cycle set wins
    istat_d = (istat_q & ~istat_clr_s) | {ext_irq & ~ext_prev_q, timer_evt_s};

    // Rising edges are dropped while a pulse runs or NMI is disabled
    nmi_rise_s = sync2_q & ~sync3_q;
    if (pulse_cnt_q != 8'h00) begin
      pulse_cnt_d = pulse_cnt_q - 8'h01;
    end else if (nmi_rise_s && nmien_q) begin
      pulse_cnt_d = PULSE_LEN;
    end else begin
      pulse_cnt_d = 8'h00;
    end

    rdata_d = rd_s ? rd_mux_s : 8'h00;
    hit_d   = rd_s;
    irq_n_d = ~|(istat_q & ien_q);
    nmi_n_d = (pulse_cnt_d == 8'h00);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trl_q       <= 8'h00;
      trh_q       <= 8'h00;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      count_q     <= 16'h0000;
      shadow_q    <= 8'h00;
      istat_q     <= 4'h0;
      ien_q       <= 4'h0;
      nmien_q     <= 1'b0;
      ext_prev_q  <= 3'b000;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      pulse_cnt_q <= 8'h00;
      rdata_q     <= 8'h00;
      hit_q       <= 1'b0;
      irq_n_q     <= 1'b1;
      nmi_n_q     <= 1'b1;
    end else begin
      trl_q       <= trl_d;
      trh_q       <= trh_d;
      en_q        <= en_d;
      ar_q        <= ar_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      istat_q     <= istat_d;
      ien_q       <= ien_d;
      nmien_q     <= nmien_d;
      ext_prev_q  <= ext_irq;
      sync1_q     <= nmi_btn;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      pulse_cnt_q <= pulse_cnt_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      irq_n_q     <= irq_n_d;
      nmi_n_q     <= nmi_n_d;
    end
  end

  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign irq_n = irq_n_q;
  assign nmi_n = nmi_n_q;

endmodule

// File: tb/tb_fc8_sysctl.sv
module tb_fc8_sysctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic        hit;
  logic        irq_n;
  logic        nmi_n;
  logic [2:0]  ext_irq;
  logic        nmi_btn;

  int checks   = 0;
  int failures = 0;

  fc8_sysctl #(.BASE(16'hFF00), .NMI_PULSE(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .hit(hit), .irq_n(irq_n), .nmi_n(nmi_n),
    .ext_irq(ext_irq), .nmi_btn(nmi_btn)
  );

  always #5 clk = ~clk;

  // Reference model state (behavioural, integer arithmetic)
  int         m_trl, m_trh, m_count, m_shadow, m_pulse_left;
  bit         m_en, m_ar, m_nmien;
  bit [3:0]   m_istat, m_ien;
  bit [2:0]   m_prev;
  bit         m_hist[3];
  logic [7:0] e_rdata;
  bit         e_hit, e_irq_n, e_nmi_n;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input int off);
    case (off)
      0: return 8'(m_trl);
      1: return 8'(m_trh);
      2: return 8'(m_ar * 2 + m_en);
      3: return 8'(m_count % 256);
      4: return 8'(m_shadow);
      5: return 8'(m_istat);
      6: return 8'(m_ien);
      7: return 8'(m_nmien);
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the specified behaviour, using the inputs at that edge
  task automatic model_edge();
    int off, reload, n_count, n_trl, n_trh;
    bit win, n_en, n_ar, n_nmien, rise;
    bit [3:0] set, clr, n_ien;
    if (!rst_n) begin
      m_trl = 0; m_trh = 0; m_count = 0; m_shadow = 0; m_pulse_left = 0;
      m_en = 0; m_ar = 0; m_nmien = 0; m_istat = 0; m_ien = 0; m_prev = 0;
      m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
      e_rdata = 8'h00; e_hit = 0; e_irq_n = 1; e_nmi_n = 1;
      return;
    end
    off = int'(addr) % 16;
    win = (int'(addr) / 16) == 16'h0FF0;
    reload = m_trh * 256 + m_trl;
    n_count = m_count; n_en = m_en; n_ar = m_ar; n_trl = m_trl; n_trh = m_trh;
    n_ien = m_ien; n_nmien = m_nmien; set = 4'h0; clr = 4'h0;

    e_hit   = win && !we;
    e_rdata = e_hit ? model_read(off) : 8'h00;
    e_irq_n = ((m_istat & m_ien) == 4'h0);

    if (m_en) begin
      if (m_count == 0) begin
        set[0] = 1'b1;
        if (m_ar) n_count = reload;
        else n_en = 1'b0;
      end else begin
        n_count = m_count - 1;
      end
    end
    set[3:1] = ext_irq & ~m_prev;

    if (win && we) begin
      case (off)
        0: n_trl = int'(wdata);
        1: n_trh = int'(wdata);
        2: begin
          if (wdata[0] && !m_en) n_count = reload;
          n_en = wdata[0];
          n_ar = wdata[1];
        end
        5: clr = wdata[3:0];
        6: n_ien = wdata[3:0];
        7: n_nmien = wdata[0];
        default: ;
      endcase
    end
    if (win && !we && off == 3) m_shadow = m_count / 256;

    rise = m_hist[1] && !m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = nmi_btn;
    if (m_pulse_left > 0) m_pulse_left--;
    else if (rise && m_nmien) m_pulse_left = 4;
    e_nmi_n = (m_pulse_left == 0);

    m_istat = (m_istat & ~clr) | set;
    m_count = n_count; m_en = n_en; m_ar = n_ar; m_trl = n_trl; m_trh = n_trh;
    m_ien = n_ien; m_nmien = n_nmien; m_prev = ext_irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("rdata", 16'(rdata), 16'(e_rdata));
    check_val("hit", 16'(hit), 16'(e_hit));
    check_val("irq_n", 16'(irq_n), 16'(e_irq_n));
    check_val("nmi_n", 16'(nmi_n), 16'(e_nmi_n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; we = 1'b1; wdata = d;
    step();
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a; we = 1'b0;
    step();
    d = rdata;
    addr = 16'h0000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n, lows;
    bit [7:0] ar_exp[3];
    rst_n = 1'b0; addr = 16'h0000; wdata = 8'h00; we = 1'b0;
    ext_irq = 3'b000; nmi_btn = 1'b0;

    // Reset and defaults
    idle(2);
    check_val("rst_irq_n", 16'(irq_n), 16'h0001);
    check_val("rst_nmi_n", 16'(nmi_n), 16'h0001);
    check_val("rst_hit", 16'(hit), 16'h0000);
    check_val("rst_rdata", 16'(rdata), 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd(16'(16'hFF00 + i), d);
      check_val("dflt_read", 16'(d), 16'h0000);
      check_val("dflt_hit", 16'(hit), 16'h0001);
    end

    // One-shot timer
    wr(16'hFF00, 8'h05); wr(16'hFF01, 8'h00); wr(16'hFF06, 8'h01); wr(16'hFF02, 8'h01);
    n = 0;
    while (irq_n === 1'b1 && n < 20) begin idle(1); n++; end
    check_val("oneshot_irq_lat", 16'(n), 16'd7);
    rd(16'hFF02, d); check_val("oneshot_tctrl", 16'(d), 16'h0000);
    rd(16'hFF05, d); check_val("oneshot_istat", 16'(d), 16'h0001);
    wr(16'hFF05, 8'h01); idle(1);
    check_val("oneshot_w1c_irq", 16'(irq_n), 16'h0001);

    // Auto-reload period and CNTL/CNTH shadow
    wr(16'hFF06, 8'h00);
    wr(16'hFF00, 8'h02); wr(16'hFF01, 8'h00); wr(16'hFF02, 8'h03);
    ar_exp[0] = 8'h02; ar_exp[1] = 8'h01; ar_exp[2] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      rd(16'hFF03, d);
      check_val("ar_count", 16'(d), 16'(ar_exp[k % 3]));
    end
    wr(16'hFF02, 8'h00);
    wr(16'hFF00, 8'h35); wr(16'hFF01, 8'h12);
    wr(16'hFF02, 8'h01); wr(16'hFF02, 8'h00);
    wr(16'hFF00, 8'h34);
    rd(16'hFF03, d); check_val("cntl", 16'(d), 16'h0034);
    rd(16'hFF04, d); check_val("cnth", 16'(d), 16'h0012);
    wr(16'hFF05, 8'h0F);

    // External IRQ and W1C race
    wr(16'hFF06, 8'h00); wr(16'hFF05, 8'h0F);
    ext_irq = 3'b010; idle(1); ext_irq = 3'b000;
    rd(16'hFF05, d); check_val("ext_istat", 16'(d), 16'h0004);
    check_val("ext_masked_irq", 16'(irq_n), 16'h0001);
    wr(16'hFF06, 8'h04); idle(1);
    check_val("ext_irq_n", 16'(irq_n), 16'h0000);
    ext_irq = 3'b010; wr(16'hFF05, 8'h04); ext_irq = 3'b000;
    rd(16'hFF05, d); check_val("w1c_race", 16'(d), 16'h0004);
    wr(16'hFF05, 8'h0F); wr(16'hFF06, 8'h00);

    // NMI pulse width and ignored mid-pulse edge
    wr(16'hFF07, 8'h01);
    nmi_btn = 1'b1;
    n = 0;
    while (nmi_n === 1'b1 && n < 10) begin idle(1); n++; end
    check_val("nmi_lat", 16'(n), 16'd3);
    lows = (nmi_n === 1'b0) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) nmi_btn = 1'b0;
      if (i == 1) nmi_btn = 1'b1;
      idle(1);
      if (nmi_n === 1'b0) lows++;
    end
    check_val("nmi_width", 16'(lows), 16'd4);
    nmi_btn = 1'b0; idle(4);
    wr(16'hFF07, 8'h00);
    nmi_btn = 1'b1; lows = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (nmi_n === 1'b0) lows++;
    end
    check_val("nmi_disabled", 16'(lows), 16'd0);

    // Reset during a pulse
    nmi_btn = 1'b0; wr(16'hFF07, 8'h01); idle(3);
    nmi_btn = 1'b1; n = 0;
    while (nmi_n === 1'b1 && n < 10) begin idle(1); n++; end
    check_val("nmi_pre_rst", 16'(nmi_n), 16'h0000);
    rst_n = 1'b0; idle(1);
    check_val("nmi_rst_abort", 16'(nmi_n), 16'h0001);
    rst_n = 1'b1; nmi_btn = 1'b0; idle(2);

    // Decode boundaries
    wr(16'hFF00, 8'hAA); wr(16'hFEFF, 8'h55); wr(16'hFF10, 8'h55); wr(16'hFF08, 8'h77);
    rd(16'hFF00, d); check_val("dec_trl", 16'(d), 16'h00AA);
    rd(16'hFF08, d); check_val("dec_off8", 16'(d), 16'h0000);
    rd(16'hFF0F, d); check_val("dec_offF", 16'(d), 16'h0000);
    check_val("dec_offF_hit", 16'(hit), 16'h0001);
    rd(16'h8000, d); check_val("dec_oow_hit", 16'(hit), 16'h0000);

    // Randomised traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) != 0) addr = 16'hFF00 | 16'($urandom_range(0, 15));
      else addr = 16'($urandom);
      we = ($urandom_range(0, 2) == 0);
      wdata = 8'($urandom);
      if (addr == 16'hFF01) wdata = wdata & 8'h01;
      if ($urandom_range(0, 7) == 0) ext_irq = ext_irq ^ 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) nmi_btn = ~nmi_btn;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
